// File: rtl/writeback_unit.sv
// Writeback stage: arbitrates EXU/LSU results (LSU first), formats loads, registers the RF write port,
// and tracks per-register pending writes for decode's RAW/WAW stall; result-to-write latency is one cycle.
module writeback_unit #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  issue_valid,
  input  logic                  issue_wen,
  input  logic [ADDR_WIDTH-1:0] issue_rd,
  output logic                  issue_ready,
  input  logic [ADDR_WIDTH-1:0] rs1,
  input  logic [ADDR_WIDTH-1:0] rs2,
  output logic                  hazard,
  input  logic                  exu_valid,
  output logic                  exu_ready,
  input  logic                  exu_wen,
  input  logic [ADDR_WIDTH-1:0] exu_rd,
  input  logic [DATA_WIDTH-1:0] exu_data,
  input  logic                  lsu_valid,
  output logic                  lsu_ready,
  input  logic [ADDR_WIDTH-1:0] lsu_rd,
  input  logic [31:0]           lsu_rdata,
  input  logic [1:0]            lsu_offset,
  input  logic [2:0]            lsu_funct3,
  output logic                  rf_wen,
  output logic [ADDR_WIDTH-1:0] rf_waddr,
  output logic [DATA_WIDTH-1:0] rf_wdata
);

  localparam int NREG = 2 ** ADDR_WIDTH;

  logic                  rf_wen_q, rf_wen_d;
  logic [ADDR_WIDTH-1:0] rf_waddr_q, rf_waddr_d;
  logic [DATA_WIDTH-1:0] rf_wdata_q, rf_wdata_d;
  logic [NREG-1:0]       busy_q, busy_d;

  logic        lsu_fire, exu_fire, issue_fire;
  logic [31:0] byte_shift, half_shift, lsu_fmt;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  assign lsu_ready   = !rst;
  assign exu_ready   = !rst && !lsu_valid;
  assign issue_ready = !rst && (!issue_wen || issue_rd == '0 || !busy_q[issue_rd]);

  assign lsu_fire   = lsu_valid && lsu_ready;
  assign exu_fire   = exu_valid && exu_ready;
  assign issue_fire = issue_valid && issue_ready;

  assign hazard = (rs1 != '0 && busy_q[rs1]) || (rs2 != '0 && busy_q[rs2]);

  // Halfword select uses only offset[1]; misaligned halfwords are not split.
  assign byte_shift = lsu_rdata >> {lsu_offset, 3'b000};
  assign half_shift = lsu_rdata >> {lsu_offset[1], 4'b0000};
  assign ld_byte    = byte_shift[7:0];
  assign ld_half    = half_shift[15:0];

  always_comb begin
    lsu_fmt = lsu_rdata;
    case (lsu_funct3)
      3'b000:  lsu_fmt = {{24{ld_byte[7]}}, ld_byte};
      3'b100:  lsu_fmt = {24'h0, ld_byte};
      3'b001:  lsu_fmt = {{16{ld_half[15]}}, ld_half};
      3'b101:  lsu_fmt = {16'h0, ld_half};
      default: lsu_fmt = lsu_rdata;
    endcase
  end

  always_comb begin
    rf_wen_d   = 1'b0;
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;
    if (lsu_fire) begin
      rf_wen_d   = (lsu_rd != '0);
      rf_waddr_d = lsu_rd;
      rf_wdata_d = DATA_WIDTH'(lsu_fmt);
    end else if (exu_fire && exu_wen) begin
      rf_wen_d   = (exu_rd != '0);
      rf_waddr_d = exu_rd;
      rf_wdata_d = exu_data;
    end
  end

  // Clear first so that a same-index set in this cycle takes precedence.
  always_comb begin
    busy_d = busy_q;
    if (rf_wen_q) busy_d[rf_waddr_q] = 1'b0;
    if (issue_fire && issue_wen && issue_rd != '0) busy_d[issue_rd] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rf_wen_q   <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
      busy_q     <= '0;
    end else begin
      rf_wen_q   <= rf_wen_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
      busy_q     <= busy_d;
    end
  end

  assign rf_wen   = rf_wen_q;
  assign rf_waddr = rf_waddr_q;
  assign rf_wdata = rf_wdata_q;

endmodule

// File: tb/tb_writeback_unit.sv
// Directed bench for writeback_unit: load-format table plus hand-written handshake/scoreboard sequences.
module tb_writeback_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        issue_valid, issue_wen, issue_ready;
  logic [4:0]  issue_rd, rs1, rs2;
  logic        hazard;
  logic        exu_valid, exu_ready, exu_wen;
  logic [4:0]  exu_rd;
  logic [31:0] exu_data;
  logic        lsu_valid, lsu_ready;
  logic [4:0]  lsu_rd;
  logic [31:0] lsu_rdata;
  logic [1:0]  lsu_offset;
  logic [2:0]  lsu_funct3;
  logic        rf_wen;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  writeback_unit #(.ADDR_WIDTH(5), .DATA_WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .issue_valid(issue_valid), .issue_wen(issue_wen), .issue_rd(issue_rd), .issue_ready(issue_ready),
    .rs1(rs1), .rs2(rs2), .hazard(hazard),
    .exu_valid(exu_valid), .exu_ready(exu_ready), .exu_wen(exu_wen), .exu_rd(exu_rd), .exu_data(exu_data),
    .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd), .lsu_rdata(lsu_rdata),
    .lsu_offset(lsu_offset), .lsu_funct3(lsu_funct3),
    .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata)
  );

  typedef struct {
    logic [31:0] rdata;
    logic [1:0]  off;
    logic [2:0]  f3;
    logic [4:0]  rd;
    logic        exp_wen;
    logic [31:0] exp_data;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  // Advance past the next active edge; registered outputs are then stable.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vecs[0]  = '{32'h8070F0A5, 2'd0, 3'b000, 5'd1,  1'b1, 32'hFFFFFFA5};
    vecs[1]  = '{32'h8070F0A5, 2'd3, 3'b100, 5'd2,  1'b1, 32'h00000080};
    vecs[2]  = '{32'h8070F0A5, 2'd2, 3'b001, 5'd3,  1'b1, 32'hFFFF8070};
    vecs[3]  = '{32'h8070F0A5, 2'd0, 3'b101, 5'd4,  1'b1, 32'h0000F0A5};
    vecs[4]  = '{32'h8070F0A5, 2'd0, 3'b010, 5'd6,  1'b1, 32'h8070F0A5};
    vecs[5]  = '{32'h8070F0A5, 2'd1, 3'b000, 5'd14, 1'b1, 32'hFFFFFFF0};
    vecs[6]  = '{32'h8070F0A5, 2'd2, 3'b000, 5'd15, 1'b1, 32'h00000070};
    vecs[7]  = '{32'h8070F0A5, 2'd3, 3'b001, 5'd16, 1'b1, 32'hFFFF8070};
    vecs[8]  = '{32'h8070F0A5, 2'd0, 3'b001, 5'd17, 1'b1, 32'hFFFFF0A5};
    vecs[9]  = '{32'h8070F0A5, 2'd2, 3'b101, 5'd18, 1'b1, 32'h00008070};
    vecs[10] = '{32'h12345678, 2'd1, 3'b011, 5'd19, 1'b1, 32'h12345678};
    vecs[11] = '{32'hCAFEBABE, 2'd0, 3'b010, 5'd0,  1'b0, 32'hCAFEBABE};

    rst = 1'b1;
    issue_valid = 0; issue_wen = 0; issue_rd = 0; rs1 = 0; rs2 = 0;
    exu_valid = 0; exu_wen = 0; exu_rd = 0; exu_data = 0;
    lsu_valid = 0; lsu_rd = 0; lsu_rdata = 0; lsu_offset = 0; lsu_funct3 = 0;

    // Reset state
    step(); step();
    lsu_valid = 1; exu_valid = 1; issue_valid = 1; issue_wen = 1; issue_rd = 5;
    #1;
    chk("rst_rf_wen", {31'b0, rf_wen}, 32'd0);
    chk("rst_rf_waddr", {27'b0, rf_waddr}, 32'd0);
    chk("rst_rf_wdata", rf_wdata, 32'd0);
    chk("rst_lsu_ready", {31'b0, lsu_ready}, 32'd0);
    chk("rst_exu_ready", {31'b0, exu_ready}, 32'd0);
    chk("rst_issue_ready", {31'b0, issue_ready}, 32'd0);
    step();
    lsu_valid = 0; exu_valid = 0; issue_valid = 0;
    rst = 0;
    #1;
    chk("post_rst_no_write", {31'b0, rf_wen}, 32'd0);

    // Issue rd 5, then EXU result for rd 5
    rs1 = 5; issue_valid = 1; issue_wen = 1; issue_rd = 5;
    #1;
    chk("issue5_ready", {31'b0, issue_ready}, 32'd1);
    chk("hazard_before_issue", {31'b0, hazard}, 32'd0);
    step();
    issue_valid = 0;
    #1;
    chk("hazard_rs1_5", {31'b0, hazard}, 32'd1);
    rs1 = 0; rs2 = 5;
    #1;
    chk("hazard_rs2_5", {31'b0, hazard}, 32'd1);
    chk("waw_issue5_stall", {31'b0, issue_ready}, 32'd0);
    exu_valid = 1; exu_wen = 1; exu_rd = 5; exu_data = 32'h1234;
    #1;
    chk("exu_ready_idle", {31'b0, exu_ready}, 32'd1);
    step();
    exu_valid = 0;
    #1;
    chk("exu5_rf_wen", {31'b0, rf_wen}, 32'd1);
    chk("exu5_rf_waddr", {27'b0, rf_waddr}, 32'd5);
    chk("exu5_rf_wdata", rf_wdata, 32'h1234);
    chk("exu5_hazard_n1", {31'b0, hazard}, 32'd1);
    step();
    chk("exu5_hazard_n2", {31'b0, hazard}, 32'd0);
    chk("exu5_rf_wen_off", {31'b0, rf_wen}, 32'd0);
    rs2 = 0;

    // Load formatting table
    for (int i = 0; i < 12; i++) begin
      lsu_valid = 1; lsu_rdata = vecs[i].rdata; lsu_offset = vecs[i].off;
      lsu_funct3 = vecs[i].f3; lsu_rd = vecs[i].rd;
      step();
      lsu_valid = 0;
      #1;
      chk($sformatf("ld%0d_wen", i), {31'b0, rf_wen}, {31'b0, vecs[i].exp_wen});
      chk($sformatf("ld%0d_waddr", i), {27'b0, rf_waddr}, {27'b0, vecs[i].rd});
      chk($sformatf("ld%0d_wdata", i), rf_wdata, vecs[i].exp_data);
    end
    step();

    // LSU and EXU together: LSU first, EXU next cycle, no duplicate
    exu_valid = 1; exu_wen = 1; exu_rd = 10; exu_data = 32'hAAAA;
    lsu_valid = 1; lsu_rd = 11; lsu_rdata = 32'h55; lsu_offset = 0; lsu_funct3 = 3'b010;
    #1;
    chk("arb_exu_ready", {31'b0, exu_ready}, 32'd0);
    chk("arb_lsu_ready", {31'b0, lsu_ready}, 32'd1);
    step();
    lsu_valid = 0;
    #1;
    chk("arb_first_waddr", {27'b0, rf_waddr}, 32'd11);
    chk("arb_first_wdata", rf_wdata, 32'h55);
    chk("arb_exu_ready2", {31'b0, exu_ready}, 32'd1);
    step();
    exu_valid = 0;
    #1;
    chk("arb_second_wen", {31'b0, rf_wen}, 32'd1);
    chk("arb_second_waddr", {27'b0, rf_waddr}, 32'd10);
    chk("arb_second_wdata", rf_wdata, 32'hAAAA);
    step();
    chk("arb_no_dup", {31'b0, rf_wen}, 32'd0);

    // rd 0 issue and result; EXU result without write
    issue_valid = 1; issue_wen = 1; issue_rd = 0;
    #1;
    chk("rd0_issue_ready", {31'b0, issue_ready}, 32'd1);
    step();
    chk("rd0_issue_ready_again", {31'b0, issue_ready}, 32'd1);
    issue_valid = 0;
    exu_valid = 1; exu_wen = 1; exu_rd = 0; exu_data = 32'hDEAD;
    step();
    exu_wen = 0; exu_rd = 9; exu_data = 32'hBEEF;
    #1;
    chk("rd0_rf_wen", {31'b0, rf_wen}, 32'd0);
    step();
    exu_valid = 0;
    #1;
    chk("nowen_rf_wen", {31'b0, rf_wen}, 32'd0);
    chk("nowen_hold_waddr", {27'b0, rf_waddr}, 32'd0);
    chk("nowen_hold_wdata", rf_wdata, 32'hDEAD);

    // WAW on rd 7
    issue_valid = 1; issue_wen = 1; issue_rd = 7;
    step();
    #1;
    chk("waw7_stall", {31'b0, issue_ready}, 32'd0);
    exu_valid = 1; exu_wen = 1; exu_rd = 7; exu_data = 32'h77;
    step();
    exu_valid = 0;
    #1;
    chk("waw7_write", {31'b0, rf_wen}, 32'd1);
    chk("waw7_stall_n1", {31'b0, issue_ready}, 32'd0);
    step();
    chk("waw7_ready_n2", {31'b0, issue_ready}, 32'd1);
    issue_valid = 0;
    step();

    // Reset mid-operation
    issue_valid = 1; issue_wen = 1; issue_rd = 12;
    step();
    issue_rd = 13;
    step();
    issue_valid = 0;
    exu_valid = 1; exu_wen = 1; exu_rd = 12; exu_data = 32'h1212;
    step();
    exu_valid = 0;
    rst = 1;
    lsu_valid = 1; lsu_rd = 20; lsu_rdata = 32'h99; lsu_funct3 = 3'b010;
    rs1 = 13; rs2 = 12;
    #1;
    chk("midrst_pending_wen", {31'b0, rf_wen}, 32'd1);
    chk("midrst_lsu_ready", {31'b0, lsu_ready}, 32'd0);
    chk("midrst_hazard_before", {31'b0, hazard}, 32'd1);
    step();
    rst = 0; lsu_valid = 0;
    #1;
    chk("midrst_rf_wen", {31'b0, rf_wen}, 32'd0);
    chk("midrst_waddr", {27'b0, rf_waddr}, 32'd0);
    chk("midrst_busy_clear", {31'b0, hazard}, 32'd0);
    step();
    chk("midrst_dropped", {31'b0, rf_wen}, 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/writeback_unit.md
# writeback_unit

Writeback stage of the 32-bit RISC-V core, sitting directly upstream of the register file. It accepts completed results from the execute unit (EXU) and the load/store unit (LSU), formats load data, and drives the register-file write port from a registered output. It also keeps a per-register busy scoreboard that decode uses to stall on RAW and WAW hazards.

## Interface
- ADDR_WIDTH, 5, register index width; the file has 2**ADDR_WIDTH entries.
- DATA_WIDTH, 32, register data width; load formatting assumes 32.

- clk  in  1  clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- issue_valid  in  1  decode presents an instruction.
- issue_wen  in  1  the instruction writes rd.
- issue_rd  in  ADDR_WIDTH  destination register.
- issue_ready  out  1  decode may issue.
- rs1, rs2  in  ADDR_WIDTH  source registers of the instruction in decode.
- hazard  out  1  a source is pending a write.
- exu_valid / exu_ready  in / out  1  EXU result handshake.
- exu_wen  in  1  EXU result writes rd.
- exu_rd  in  ADDR_WIDTH  EXU destination register.
- exu_data  in  DATA_WIDTH  EXU result.
- lsu_valid / lsu_ready  in / out  1  LSU load-result handshake.
- lsu_rd  in  ADDR_WIDTH  load destination register.
- lsu_rdata  in  32  raw aligned memory word.
- lsu_offset  in  2  byte address bits [1:0].
- lsu_funct3  in  3  load type.
- rf_wen  out  1  register-file write enable.
- rf_waddr  out  ADDR_WIDTH  write address.
- rf_wdata  out  DATA_WIDTH  write data.

## Operation
**Handshake and arbitration**
- A transfer fires when valid and ready are both high at a posedge.
- The LSU has priority.
  - lsu_ready = !rst.
  - exu_ready = !rst && !lsu_valid.
- At most one result is accepted per cycle.

**Load formatting** (LSU results only)
- funct3 000 (lb): byte lsu_rdata[8*offset +: 8], sign-extended.
- funct3 100 (lbu): same byte, zero-extended.
- funct3 001 (lh): halfword lsu_rdata[16*offset[1] +: 16], sign-extended; offset[0] is ignored.
- funct3 101 (lhu): same halfword, zero-extended.
- funct3 010 (lw) and all other codes: lsu_rdata passes through unchanged.

**Output register**
- On an accepted result with a write, the next cycle holds:
  - rf_wen = 1 if rd != 0, else 0;
  - rf_waddr = rd;
  - rf_wdata = the formatted data.
- On an accepted EXU result with exu_wen = 0, or with no transfer, rf_wen = 0. rf_waddr and rf_wdata hold their previous values.

**Scoreboard**
- busy[] holds 2**ADDR_WIDTH bits. busy[0] is always 0.
- issue_ready = !rst && (!issue_wen || issue_rd == 0 || !busy[issue_rd]). This stalls WAW.
- Set: issue fire with issue_wen and issue_rd != 0 sets busy[issue_rd].
- Clear: a posedge where rf_wen = 1 clears busy[rf_waddr].
- If set and clear target the same index in the same cycle, set wins.
- A write to a register that is not busy is still performed; the clear is a no-op.
- hazard = (rs1 != 0 && busy[rs1]) || (rs2 != 0 && busy[rs2]). This output is combinational.
- There is no bypass. Decode reads the register file only after hazard drops.

## Timing
- Reset values: rf_wen = 0, rf_waddr = 0, rf_wdata = 0, busy all 0.
- While rst is high: issue_ready = 0, exu_ready = 0, lsu_ready = 0.
- Reset asserted mid-operation:
  - discards any pending output write (rf_wen = 0 the next cycle);
  - clears all busy bits;
  - drops any result presented in that cycle.
- Latency for a result accepted at edge N:
  - rf_wen is high during cycle N+1;
  - the register file and busy[] update at edge N+2;
  - the new value is readable, and hazard for that rd is low, from cycle N+2.
- Throughput is one write per cycle. Back-to-back LSU results starve the EXU; there is no fairness.
- Issue and result for the same rd in the same cycle cannot occur: issue_ready is low while busy.

## Test plan
- Reset, then issue rd = 5 → busy[5] set; rs1 = 5 gives hazard = 1. EXU result rd = 5, data 0x1234 accepted at edge N → rf_wen = 1, waddr 5, wdata 0x1234 in cycle N+1; hazard = 0 from N+2.
- Loads on word 0x8070F0A5:
  - lb at offset 0 → 0xFFFFFFA5;
  - lbu at offset 3 → 0x00000080;
  - lh at offset 2 → 0xFFFF8070;
  - lhu at offset 0 → 0x0000F0A5;
  - lw → 0x8070F0A5.
- exu_valid and lsu_valid both high → LSU written first with exu_ready = 0; the EXU result is written on the following cycle. Writes are in order, with no drop or duplicate.
- rd = 0: issue with rd 0 → issue_ready = 1 and busy unchanged; a result to rd 0 → rf_wen = 0.
- WAW: rd 7 busy and issue rd 7 → issue_ready = 0 until the cycle after the rd 7 write lands.
- rst pulsed in the cycle a result is accepted → next cycle rf_wen = 0, all busy bits clear, all readies 0 during rst.
